alu_exec_unit: RTL and testbench

//  Command-side responder for the 32-bit ALU: accepts operand/opcode commands over a

---
 rtl/alu_exec_unit.sv | 160 ++++++++++++++++
 tb/tb_alu_exec_unit.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: two-stage ALU responder, cmd handshake -> S1 capture -> S2 result.
// Ports: cmd_* in (valid/ready), res_* out (valid/ready), op_count/sticky_v stats, clr_stats.
module alu_exec_unit #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [2:0]       cmd_sel,
    input  logic             cmd_cin,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_out,
    output logic [3:0]       res_status,
    output logic [TAG_W-1:0] res_tag,
    output logic [CNT_W-1:0] op_count,
    output logic             sticky_v,
    input  logic             clr_stats
);

    localparam int MSB = WIDTH - 1;

    logic             s1_full_q, s1_full_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic [WIDTH-1:0] s1_b_q, s1_b_d;
    logic [2:0]       s1_sel_q, s1_sel_d;
    logic             s1_cin_q, s1_cin_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

    logic             res_valid_q, res_valid_d;
    logic [WIDTH-1:0] res_out_q, res_out_d;
    logic [3:0]       res_status_q, res_status_d;
    logic [TAG_W-1:0] res_tag_q, res_tag_d;

    logic [CNT_W-1:0] op_count_q, op_count_d;
    logic             sticky_v_q, sticky_v_d;

    logic             s2_load, cmd_fire, retire;
    logic [WIDTH:0]   add_w, sub_w;
    logic [WIDTH-1:0] alu_out;
    logic             alu_c, alu_v;

    // S1 drains into S2 whenever S2 is empty or retiring this cycle;
    // cmd_ready therefore depends on res_ready but never on cmd_valid.
    assign retire    = res_valid_q && res_ready;
    assign s2_load   = s1_full_q && (!res_valid_q || res_ready);
    assign cmd_ready = !s1_full_q || s2_load;
    assign cmd_fire  = cmd_valid && cmd_ready;

    always_comb begin
        add_w   = {1'b0, s1_a_q} + {1'b0, s1_b_q}
                + {{WIDTH{1'b0}}, s1_cin_q};
        // A + ~B + 1: carry out is the "no borrow" flag.
        sub_w   = {1'b0, s1_a_q} + {1'b0, ~s1_b_q}
                + {{WIDTH{1'b0}}, 1'b1};
        alu_out = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (s1_sel_q)
            3'b000: begin
                alu_out = add_w[MSB:0];
                alu_c   = add_w[WIDTH];
                alu_v   = (s1_a_q[MSB] == s1_b_q[MSB])
                       && (add_w[MSB] != s1_a_q[MSB]);
            end
            3'b001: begin
                alu_out = sub_w[MSB:0];
                alu_c   = sub_w[WIDTH];
                alu_v   = (s1_a_q[MSB] != s1_b_q[MSB])
                       && (sub_w[MSB] != s1_a_q[MSB]);
            end
            3'b010: alu_out = s1_a_q ^ s1_b_q;
            3'b011: alu_out = s1_a_q & s1_b_q;
            3'b100: alu_out = s1_a_q | s1_b_q;
            3'b101: alu_out = ~(s1_a_q | s1_b_q);
            // Shift by the full A value: amounts >= WIDTH yield zero.
            3'b110: alu_out = s1_b_q >> s1_a_q;
            default: alu_out = s1_b_q << s1_a_q;
        endcase
    end

    always_comb begin
        s1_full_d = s1_full_q;
        if (cmd_fire)
            s1_full_d = 1'b1;
        else if (s2_load)
            s1_full_d = 1'b0;
        s1_a_d   = cmd_fire ? cmd_a   : s1_a_q;
        s1_b_d   = cmd_fire ? cmd_b   : s1_b_q;
        s1_sel_d = cmd_fire ? cmd_sel : s1_sel_q;
        s1_cin_d = cmd_fire ? cmd_cin : s1_cin_q;
        s1_tag_d = cmd_fire ? cmd_tag : s1_tag_q;

        res_valid_d = res_valid_q;
        if (s2_load)
            res_valid_d = 1'b1;
        else if (retire)
            res_valid_d = 1'b0;
        res_out_d    = s2_load ? alu_out : res_out_q;
        res_status_d = s2_load
                     ? {alu_v, alu_c, alu_out[MSB], alu_out == '0}
                     : res_status_q;
        res_tag_d    = s2_load ? s1_tag_q : res_tag_q;

        // Clear beats a coincident retire.
        op_count_d = op_count_q;
        sticky_v_d = sticky_v_q;
        if (clr_stats) begin
            op_count_d = '0;
            sticky_v_d = 1'b0;
        end else if (retire) begin
            op_count_d = op_count_q + 1'b1;
            sticky_v_d = sticky_v_q | res_status_q[3];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_full_q    <= 1'b0;
            s1_a_q       <= '0;
            s1_b_q       <= '0;
            s1_sel_q     <= '0;
            s1_cin_q     <= 1'b0;
            s1_tag_q     <= '0;
            res_valid_q  <= 1'b0;
            res_out_q    <= '0;
            res_status_q <= '0;
            res_tag_q    <= '0;
            op_count_q   <= '0;
            sticky_v_q   <= 1'b0;
        end else begin
            s1_full_q    <= s1_full_d;
            s1_a_q       <= s1_a_d;
            s1_b_q       <= s1_b_d;
            s1_sel_q     <= s1_sel_d;
            s1_cin_q     <= s1_cin_d;
            s1_tag_q     <= s1_tag_d;
            res_valid_q  <= res_valid_d;
            res_out_q    <= res_out_d;
            res_status_q <= res_status_d;
            res_tag_q    <= res_tag_d;
            op_count_q   <= op_count_d;
            sticky_v_q   <= sticky_v_d;
        end
    end

    assign res_valid  = res_valid_q;
    assign res_out    = res_out_q;
    assign res_status = res_status_q;
    assign res_tag    = res_tag_q;
    assign op_count   = op_count_q;
    assign sticky_v   = sticky_v_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed-vector bench for alu_exec_unit.
// Checks ops, flags, back-pressure ordering, stats wrap/clear and reset.
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_a = '0;
    logic [31:0] cmd_b = '0;
    logic [2:0]  cmd_sel = '0;
    logic        cmd_cin = 1'b0;
    logic [3:0]  cmd_tag = '0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [31:0] res_out;
    logic [3:0]  res_status;
    logic [3:0]  res_tag;
    logic [15:0] op_count;
    logic        sticky_v;
    logic        clr_stats = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_exec_unit dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel),
        .cmd_cin(cmd_cin), .cmd_tag(cmd_tag),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_out(res_out), .res_status(res_status),
        .res_tag(res_tag), .op_count(op_count),
        .sticky_v(sticky_v), .clr_stats(clr_stats)
    );

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single op on an idle pipe with res_ready high; optional clr at retire.
    task automatic do_op(input string name,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] sel, input logic cin,
                         input logic [3:0] tag,
                         input logic [31:0] exp_out,
                         input logic [3:0] exp_st,
                         input logic clr);
        res_ready = 1'b1;
        cmd_a = a; cmd_b = b; cmd_sel = sel;
        cmd_cin = cin; cmd_tag = tag;
        cmd_valid = 1'b1;
        #1;
        check({name, ".rdy"}, cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        check({name, ".lat1"}, res_valid, 0);
        tick();
        check({name, ".vld"}, res_valid, 1);
        check({name, ".out"}, res_out, exp_out);
        check({name, ".st"}, res_status, exp_st);
        check({name, ".tag"}, res_tag, tag);
        clr_stats = clr;
        tick();
        clr_stats = 1'b0;
        check({name, ".ret"}, res_valid, 0);
    endtask

    initial begin
        logic [3:0] got_tags[$];
        int acc, ret, seen;
        logic fc, fr;
        logic [3:0] rt;
        logic [31:0] ro;
        logic [15:0] cnt0;

        #12;
        check("rst.valid", res_valid, 0);
        check("rst.out", res_out, 0);
        check("rst.cnt", op_count, 0);
        check("rst.sticky", sticky_v, 0);
        rst_n = 1'b1;
        tick();
        check("rst.cmd_ready", cmd_ready, 1);

        do_op("add", 5, 10, 3'b000, 0, 4'h3, 32'h0F, 4'b0000, 0);
        do_op("addc", 5, 10, 3'b000, 1, 4'h4, 32'h10, 4'b0000, 0);
        do_op("sub", 5, 10, 3'b001, 1, 4'h5, 32'hFFFFFFFB, 4'b0010, 0);
        do_op("subeq", 7, 7, 3'b001, 0, 4'h5, 32'h0, 4'b0101, 0);
        do_op("shr", 3, 32'h9C, 3'b110, 0, 4'h6, 32'h13, 4'b0000, 0);
        do_op("shl", 3, 32'h1D, 3'b111, 0, 4'h7, 32'hE8, 4'b0000, 0);
        do_op("nor", 6, 32'h1D, 3'b101, 0, 4'h8, 32'hFFFFFFE0, 4'b0010, 0);
        do_op("shl40", 40, 32'h1D, 3'b111, 0, 4'h9, 32'h0, 4'b0001, 0);
        do_op("xor", 32'hF0F0, 32'h0FF0, 3'b010, 0, 4'hA, 32'hFF00, 4'b0000, 0);
        do_op("and", 32'hF0F0, 32'h0FF0, 3'b011, 0, 4'hB, 32'h00F0, 4'b0000, 0);
        do_op("or", 32'hF0F0, 32'h0FF0, 3'b100, 0, 4'hC, 32'hFFF0, 4'b0000, 0);
        do_op("z", 0, 0, 3'b000, 0, 4'h1, 32'h0, 4'b0001, 0);
        do_op("n", 0, 32'hFFFFFFFF, 3'b000, 0, 4'h2, 32'hFFFFFFFF, 4'b0010, 0);
        do_op("cz", 32'hC0000000, 32'h40000000, 3'b000, 0, 4'h3, 32'h0, 4'b0101, 0);
        check("sticky.pre", sticky_v, 0);
        do_op("vcz", 32'h80000000, 32'h80000000, 3'b000, 0, 4'h4, 32'h0, 4'b1101, 0);
        check("sticky.set", sticky_v, 1);
        check("cnt.ops", op_count, 15);

        // Back-pressure: res_ready low for 5 cycles, then drain.
        acc = 0;
        res_ready = 1'b0;
        cmd_sel = 3'b000; cmd_b = 0; cmd_cin = 0;
        cmd_tag = 4'd1; cmd_a = 32'd1;
        cmd_valid = 1'b1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            res_ready = (cyc >= 5);
            #1;
            if (cyc == 4) begin
                check("bp.ready", cmd_ready, 0);
                check("bp.acc", acc, 2);
            end
            fc = cmd_valid && cmd_ready;
            fr = res_valid && res_ready;
            rt = res_tag;
            ro = res_out;
            tick();
            if (fc) begin
                acc++;
                if (acc == 4) cmd_valid = 1'b0;
                cmd_tag = 4'(acc + 1);
                cmd_a = 32'(acc + 1);
            end
            if (fr) begin
                got_tags.push_back(rt);
                check("bp.data", ro, {28'h0, rt});
            end
        end
        res_ready = 1'b1;
        check("bp.count", got_tags.size(), 4);
        for (int i = 0; i < got_tags.size(); i++)
            check("bp.order", got_tags[i], 4'(i + 1));

        // Stats: clear, 0xFFFF retires, wrap, clear wins.
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        check("clr.cnt", op_count, 0);
        check("clr.sticky", sticky_v, 0);
        acc = 0; ret = 0;
        cmd_a = 0; cmd_b = 0; cmd_sel = 3'b000;
        cmd_valid = 1'b1;
        for (int cyc = 0; cyc < 70000 && ret < 16'hFFFF; cyc++) begin
            fc = cmd_valid && cmd_ready;
            fr = res_valid && res_ready;
            tick();
            if (fc) begin
                acc++;
                if (acc == 16'hFFFF) cmd_valid = 1'b0;
            end
            if (fr) ret++;
        end
        cmd_valid = 1'b0;
        check("stream.ret", ret, 16'hFFFF);
        check("cnt.max", op_count, 16'hFFFF);
        do_op("wrap", 1, 2, 3'b000, 0, 4'h1, 32'h3, 4'b0000, 0);
        check("cnt.wrap", op_count, 0);
        do_op("v1", 32'h7FFFFFFF, 1, 3'b000, 0, 4'h2, 32'h80000000, 4'b1010, 0);
        check("v1.sticky", sticky_v, 1);
        check("v1.cnt", op_count, 1);
        do_op("clrret", 32'h80000000, 32'h80000000, 3'b000, 0, 4'h3, 0, 4'b1101, 1);
        check("clrret.cnt", op_count, 0);
        check("clrret.sticky", sticky_v, 0);
        do_op("post", 1, 1, 3'b000, 0, 4'h4, 32'h2, 4'b0000, 0);
        cnt0 = op_count;
        check("post.cnt", cnt0, 1);

        // Reset with two ops in flight.
        res_ready = 1'b0;
        cmd_valid = 1'b1;
        cmd_tag = 4'hE;
        tick();
        cmd_tag = 4'hF;
        tick();
        cmd_valid = 1'b0;
        check("inflight.vld", res_valid, 1);
        check("inflight.full", cmd_ready, 0);
        rst_n = 1'b0;
        #1;
        check("arst.vld", res_valid, 0);
        check("arst.cnt", op_count, 0);
        tick();
        tick();
        rst_n = 1'b1;
        res_ready = 1'b1;
        seen = 0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            if (res_valid) seen++;
            tick();
        end
        check("arst.noresult", seen, 0);
        check("arst.cnt2", op_count, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
